// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift/rotate engine.
package shift_pkg;

   typedef enum logic [1:0] {
      MODE_SLL  = 2'b00,
      MODE_SRA  = 2'b01,
      MODE_ROR  = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single step: shifts din by amt (0..2**STEP_LOG2) in the selected mode.
module shift_step
   import shift_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AW    = 1
) (
   input  logic [WIDTH-1:0] din,
   input  logic [AW-1:0]    amt,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] ror;

   // Rotating a doubled copy avoids a WIDTH-amt term that breaks at amt=0.
   assign ror = WIDTH'({din, din} >> amt);

   always_comb begin
      dout = din;
      case (mode)
         MODE_SLL: dout = din << amt;
         MODE_SRA: dout = $signed(din) >>> amt;
         MODE_ROR: dout = ror;
         default:  dout = din;
      endcase
   end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRA/ROR engine: shifts 2**STEP_LOG2 bits per cycle, pulses done with the result.
//
//   state | meaning
//   IDLE  | waiting for start; operands captured on accept
//   SHIFT | one step of up to 2**STEP_LOG2 bits per cycle
//   DONE  | Shift_Out valid, done=1, busy=1; returns to IDLE
module seq_shift_unit
   import shift_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int STEP_LOG2 = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WIDTH-1:0]         Shift_In,
   input  logic [$clog2(WIDTH)-1:0] Shift_Val,
   input  logic [1:0]               Mode,
   output logic [WIDTH-1:0]         Shift_Out,
   output logic                     busy,
   output logic                     done,
   output logic                     bad_mode
);

   localparam int CW = $clog2(WIDTH);
   localparam int AW = STEP_LOG2 + 1;
   localparam logic [CW:0]   STEP_N = (CW+1)'(2 ** STEP_LOG2);
   localparam logic [AW-1:0] STEP_A = AW'(2 ** STEP_LOG2);

   state_e           state;
   state_e           next_state;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] step_out;
   logic [CW-1:0]    remaining;
   logic [1:0]       mode_q;
   logic [AW-1:0]    amt;
   logic             direct_done;

   assign direct_done = (Shift_Val == '0) || (Mode == MODE_RSVD);

   always_comb begin
      amt = STEP_A;
      if ({1'b0, remaining} < STEP_N) amt = remaining[AW-1:0];
   end

   shift_step #(.WIDTH(WIDTH), .AW(AW)) u_step (
      .din  (work),
      .amt  (amt),
      .mode (mode_q),
      .dout (step_out)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = direct_done ? DONE : SHIFT;
         SHIFT:   if (remaining == CW'(amt)) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Shift_Out is loaded on the edge entering DONE so it is valid alongside done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         work      <= '0;
         remaining <= '0;
         mode_q    <= MODE_SLL;
         Shift_Out <= '0;
         bad_mode  <= 1'b0;
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (start) begin
                  work      <= Shift_In;
                  remaining <= Shift_Val;
                  mode_q    <= Mode;
                  bad_mode  <= (Mode == MODE_RSVD);
                  if (direct_done) Shift_Out <= Shift_In;
               end
            end
            SHIFT: begin
               work      <= step_out;
               remaining <= remaining - CW'(amt);
               if (next_state == DONE) Shift_Out <= step_out;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
